invader_formation: RTL and testbench

//  Multi-row, parametrised successor to the single-row invader block: marches a ROWS x COLS formation,

---
 rtl/invaders_pkg.sv | 17 +
 rtl/formation_step_timer.sv | 25 ++
 rtl/invader_formation.sv | 179 +++++++++++++++++
 tb/tb_invader_formation.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared direction constants, FSM encoding and clock scale for the invader formation
package invaders_pkg;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // clk_36MHz ticks per microsecond
  localparam int US_CLKS = 36;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    CLEARED = 2'd2,
    LANDED  = 2'd3
  } state_t;

endpackage

// File: rtl/formation_step_timer.sv
// rtl/formation_step_timer.sv - period counter that pulses q once every period clocks while en is high
module formation_step_timer #(
  parameter int W = 32
) (
  input  logic         clk_36MHz,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         q
);

  logic [W-1:0] count;

  // A shrinking period fires at once rather than waiting for a wrap
  assign q = en && ((count + W'(1)) >= period);

  always_ff @(posedge clk_36MHz) begin
    if (!reset || !en || q) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/invader_formation.sv
// rtl/invader_formation.sv - ROWS x COLS invader formation: march, descend, bullet hits, clear/land status
// Optional INVADERS_SPEEDUP_EN shortens the step period as the formation thins out.
module invader_formation
  import invaders_pkg::*;
#(
  parameter int              COLS      = 20,
  parameter int              ROWS      = 3,
  parameter logic [COLS-1:0] INIT_MASK = 'h001FF,
  parameter int              STEP_US   = 100000,
  parameter int              LEVEL_US  = 10000,
  parameter int              MIN_US    = 2000,
  parameter int              LAND_LINE = 13
) (
  input  logic                           clk_36MHz,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           bullet_valid,
  input  logic [$clog2(COLS)-1:0]        bullet_x,
  input  logic [3:0]                     bullet_y,
  input  logic [2:0]                     level,
  output logic                           hit,
  output logic [$clog2(ROWS)-1:0]        hit_row,
  output logic [$clog2(COLS)-1:0]        hit_col,
  output logic [ROWS*COLS-1:0]           rows_flat,
  output logic [3:0]                     top_line,
  output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
  output logic                           cleared,
  output logic                           landed
);

  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(ROWS*COLS+1);
  localparam int PW = 32;

  state_t          state, state_next;
  logic [COLS-1:0] rows [ROWS];
  logic [COLS-1:0] row_or;
  logic [COLS-1:0] col_mask;
  logic            dir;
  logic            step_pending;
  logic            march;
  logic            kill;
  logic [RW-1:0]   kill_row;
  logic            step_req;
  logic            do_step;
  logic            descend;
  logic [PW-1:0]   reduction;
  logic [PW-1:0]   base_clks;
  logic [PW-1:0]   period;

  function automatic logic [AW-1:0] popcount(input logic [COLS-1:0] v);
    popcount = '0;
    for (int i = 0; i < COLS; i++) begin
      popcount = popcount + AW'(v[i]);
    end
  endfunction

  always_comb begin
    alive_count = '0;
    rows_flat   = '0;
    row_or      = '0;
    for (int r = 0; r < ROWS; r++) begin
      alive_count = alive_count + popcount(rows[r]);
      rows_flat[r*COLS +: COLS] = rows[r];
      row_or = row_or | rows[r];
    end
  end

  // Out-of-range bullet_x shifts the mask to zero, so it can never hit
  assign col_mask = COLS'(1) << bullet_x;

  // Descending loop leaves the lowest matching row as the winner
  always_comb begin
    kill     = 1'b0;
    kill_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (march && bullet_valid && (bullet_y == top_line + 4'(r + 1)) && |(rows[r] & col_mask)) begin
        kill     = 1'b1;
        kill_row = RW'(r);
      end
    end
  end

  assign do_step = march && (step_req || step_pending) && !kill;
  assign descend = do_step && (((dir == LEFT) && row_or[COLS-1]) || ((dir == RIGHT) && row_or[0]));

  always_comb begin
    reduction = PW'(level) * PW'(LEVEL_US);
    if ((reduction + PW'(MIN_US)) >= PW'(STEP_US)) begin
      base_clks = PW'(MIN_US * US_CLKS);
    end else begin
      base_clks = (PW'(STEP_US) - reduction) * PW'(US_CLKS);
    end
    period = base_clks;
`ifdef INVADERS_SPEEDUP_EN
    if (alive_count == AW'(1)) begin
      period = base_clks >> 2;
    end else if (32'(alive_count) <= (ROWS * COLS / 4)) begin
      period = base_clks >> 1;
    end
    if (period < PW'(MIN_US * US_CLKS / 4)) begin
      period = PW'(MIN_US * US_CLKS / 4);
    end
`endif
  end

  formation_step_timer #(.W(PW)) u_timer (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .en        (march),
    .period    (period),
    .q         (step_req)
  );

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = MARCH;
      end
      MARCH: begin
        if ((alive_count == '0) || (kill && (alive_count == AW'(1)))) begin
          state_next = CLEARED;
        end else if (descend && ((5'(top_line) + 5'(ROWS)) >= 5'(LAND_LINE))) begin
          state_next = LANDED;
        end
      end
      default: state_next = state;
    endcase
  end

  always_comb begin
    march   = (state == MARCH);
    cleared = (state == CLEARED);
    landed  = (state == LANDED);
  end

  // A kill wins the cycle; a coincident step request waits in step_pending
  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        rows[r] <= INIT_MASK;
      end
      top_line     <= 4'd1;
      dir          <= LEFT;
      step_pending <= 1'b0;
      hit          <= 1'b0;
      hit_row      <= '0;
      hit_col      <= '0;
    end else begin
      hit <= kill;
      if (kill) begin
        rows[kill_row] <= rows[kill_row] & ~col_mask;
        hit_row        <= kill_row;
        hit_col        <= bullet_x;
        step_pending   <= step_pending | step_req;
      end else if (do_step) begin
        step_pending <= 1'b0;
        if (descend) begin
          top_line <= top_line + 4'd1;
          dir      <= ~dir;
        end else begin
          for (int r = 0; r < ROWS; r++) begin
            rows[r] <= (dir == LEFT) ? (rows[r] << 1) : (rows[r] >> 1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_invader_formation.sv
// tb/tb_invader_formation.sv - scoreboard bench for invader_formation: expected hits/steps queued, monitor compares
module tb_invader_formation;

  localparam int COLS = 20;
  localparam int ROWS = 3;
  localparam int P7   = 3 * 36;
`ifdef INVADERS_SPEEDUP_EN
  localparam int P0_EXP = 5 * 36;
`else
  localparam int P0_EXP = 10 * 36;
`endif

  logic        clk_36MHz = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        bullet_valid = 1'b0;
  logic [4:0]  bullet_x = '0;
  logic [3:0]  bullet_y = '0;
  logic [2:0]  level = '0;
  logic        hit;
  logic [1:0]  hit_row;
  logic [4:0]  hit_col;
  logic [59:0] rows_flat;
  logic [3:0]  top_line;
  logic [5:0]  alive_count;
  logic        cleared;
  logic        landed;

  invader_formation #(
    .COLS(20), .ROWS(3), .INIT_MASK(20'h001FF),
    .STEP_US(10), .LEVEL_US(1), .MIN_US(2), .LAND_LINE(13)
  ) dut (
    .clk_36MHz    (clk_36MHz),
    .reset        (reset),
    .start        (start),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .level        (level),
    .hit          (hit),
    .hit_row      (hit_row),
    .hit_col      (hit_col),
    .rows_flat    (rows_flat),
    .top_line     (top_line),
    .alive_count  (alive_count),
    .cleared      (cleared),
    .landed       (landed)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  int cyc = 0;
  always @(posedge clk_36MHz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  typedef struct { logic [59:0] rows; logic [3:0] top; int gap; } step_t;
  typedef struct { logic [1:0] row; logic [4:0] col; logic [59:0] rows; logic [5:0] alive; } hit_t;
  step_t step_q[$];
  hit_t  hit_q[$];

  // Formation model
  logic [COLS-1:0] m_rows [ROWS];
  logic [3:0]      m_top;
  logic            m_dir;

  function automatic logic [59:0] m_flat();
    logic [59:0] f = '0;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = m_rows[r];
    return f;
  endfunction

  function automatic logic [5:0] m_alive();
    logic [5:0] n = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) n = n + 6'(m_rows[r][c]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_rows[r] = 20'h001FF;
    m_top = 4'd1;
    m_dir = 1'b0;
  endtask

  task automatic push_step(input int gap);
    logic [COLS-1:0] o = '0;
    step_t s;
    for (int r = 0; r < ROWS; r++) o = o | m_rows[r];
    if (!m_dir && o[COLS-1]) begin
      m_top = m_top + 4'd1; m_dir = 1'b1;
    end else if (m_dir && o[0]) begin
      m_top = m_top + 4'd1; m_dir = 1'b0;
    end else begin
      for (int r = 0; r < ROWS; r++) m_rows[r] = m_dir ? (m_rows[r] >> 1) : (m_rows[r] << 1);
    end
    s.rows = m_flat(); s.top = m_top; s.gap = gap;
    step_q.push_back(s);
  endtask

  task automatic find_live(output int fr, output int fc);
    fr = -1; fc = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (fr < 0 && m_rows[r][c]) begin fr = r; fc = c; end
  endtask

  task automatic push_hit(input int r, input int c);
    hit_t h;
    m_rows[r][c] = 1'b0;
    h.row = 2'(r); h.col = 5'(c); h.rows = m_flat(); h.alive = m_alive();
    hit_q.push_back(h);
  endtask

  task automatic kill_cell(input int r, input int c);
    bullet_x = 5'(c);
    bullet_y = m_top + 4'(r + 1);
    push_hit(r, c);
    bullet_valid = 1'b1;
    @(negedge clk_36MHz);
    bullet_valid = 1'b0;
  endtask

  task automatic kill_first_live();
    int fr, fc;
    find_live(fr, fc);
    if (fr >= 0) kill_cell(fr, fc);
  endtask

  task automatic shoot(input logic [4:0] x, input logic [3:0] y);
    bullet_x = x; bullet_y = y; bullet_valid = 1'b1;
    @(negedge clk_36MHz);
    bullet_valid = 1'b0;
  endtask

  task automatic wait_steps(input int budget);
    int n = 0;
    while (step_q.size() != 0 && n < budget) begin
      @(negedge clk_36MHz); #1;
      n++;
    end
    if (step_q.size() != 0) begin
      flag("step_timeout");
      step_q.delete();
    end
  endtask

  task automatic run_steps(input int n, input int gap);
    for (int i = 0; i < n; i++) push_step(gap);
    wait_steps((n + 1) * 400);
  endtask

  task automatic do_reset();
    @(negedge clk_36MHz);
    reset = 1'b0; start = 1'b0; bullet_valid = 1'b0;
    repeat (2) @(negedge clk_36MHz);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic do_start();
    @(negedge clk_36MHz);
    start = 1'b1;
    @(negedge clk_36MHz);
    start = 1'b0;
  endtask

  // Monitor: every hit pulse or formation movement must match the head of its queue
  logic [63:0] prev_pos = '0;
  logic [63:0] mon_pos;
  int          last_step_cyc = 0;
  step_t       ms;
  hit_t        mh;

  initial begin
    forever begin
      @(negedge clk_36MHz);
      mon_pos = {rows_flat, top_line};
      if (reset) begin
        if (hit) begin
          if (hit_q.size() == 0) flag("unexpected_hit");
          else begin
            mh = hit_q.pop_front();
            chk("hit_row", hit_row, mh.row);
            chk("hit_col", hit_col, mh.col);
            chk("hit_rows", rows_flat, mh.rows);
            chk("hit_alive", alive_count, mh.alive);
          end
        end else if (mon_pos !== prev_pos) begin
          if (step_q.size() == 0) flag("unexpected_step");
          else begin
            ms = step_q.pop_front();
            chk("step_rows", rows_flat, ms.rows);
            chk("step_top", top_line, ms.top);
            if (ms.gap != 0) chk("step_gap", cyc - last_step_cyc, ms.gap);
          end
          last_step_cyc = cyc;
        end
      end
      prev_pos = mon_pos;
    end
  end

  int fr, fc, guard;
  logic [4:0] t4_x;
  logic [3:0] t4_y;

  initial begin
    level = 3'd7;
    do_reset();
    chk("rst_rows", rows_flat, {20'h001FF, 20'h001FF, 20'h001FF});
    chk("rst_top", top_line, 4'd1);
    chk("rst_alive", alive_count, 6'd27);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hit_row", hit_row, 2'd0);
    chk("rst_hit_col", hit_col, 5'd0);
    chk("rst_cleared", cleared, 1'b0);
    chk("rst_landed", landed, 1'b0);

    // IDLE: no hits, no motion
    shoot(5'd0, 4'd2);
    repeat (2 * P7) @(negedge clk_36MHz);
    #1 chk("idle_alive", alive_count, 6'd27);

    // Hit row 1 column 3 right after start
    do_start();
    kill_cell(1, 3);
    #1;
    chk("t3_hit_row", hit_row, 2'd1);
    chk("t3_hit_col", hit_col, 5'd3);
    chk("t3_row1", rows_flat[39:20], 20'h001F7);
    chk("t3_alive", alive_count, 6'd26);
    @(negedge clk_36MHz); #1;
    chk("t3_hit_pulse", hit, 1'b0);

    // Misses: column out of range, wrong line, dead cell
    shoot(5'd25, 4'd2);
    shoot(5'd0, 4'd5);
    shoot(5'd3, 4'd3);
    #1 chk("miss_alive", alive_count, 6'd26);

    // Eleven left shifts then a descend
    run_steps(1, 0);
    run_steps(11, P7);
    chk("t2_rows", rows_flat, {20'hFF800, 20'hFB800, 20'hFF800});
    chk("t2_top", top_line, 4'd2);

    // Kill on the request cycle: step slips one clock, timer cadence kept
    find_live(fr, fc);
    t4_x = 5'(fc);
    t4_y = m_top + 4'(fr + 1);
    push_hit(fr, fc);
    push_step(P7 + 1);
    push_step(P7 - 1);
    repeat (P7 - 1) @(negedge clk_36MHz);
    bullet_x = t4_x; bullet_y = t4_y; bullet_valid = 1'b1;
    @(negedge clk_36MHz);
    bullet_valid = 1'b0;
    wait_steps(4 * P7);

    // Clear the formation
    guard = 0;
    while (m_alive() != 0 && guard < 100) begin
      kill_first_live();
      guard++;
    end
    @(negedge clk_36MHz); #1;
    chk("t5_cleared", cleared, 1'b1);
    chk("t5_alive", alive_count, 6'd0);
    chk("t5_landed", landed, 1'b0);
    repeat (3 * P7) @(negedge clk_36MHz);
    #1;
    chk("t5_frozen_rows", rows_flat, 60'd0);
    chk("t5_frozen_top", top_line, 4'd2);

    // Mid-operation reset
    do_reset();
    chk("rst2_rows", rows_flat, {20'h001FF, 20'h001FF, 20'h001FF});
    chk("rst2_top", top_line, 4'd1);
    chk("rst2_hit_row", hit_row, 2'd0);
    chk("rst2_hit_col", hit_col, 5'd0);
    chk("rst2_cleared", cleared, 1'b0);

    // March down until the bottom row reaches the landing line
    do_start();
    run_steps(1, 0);
    guard = 0;
    while (m_top < 4'd11 && guard < 200) begin
      run_steps(1, P7);
      guard++;
    end
    repeat (2) @(negedge clk_36MHz);
    #1;
    chk("land_landed", landed, 1'b1);
    chk("land_cleared", cleared, 1'b0);
    find_live(fr, fc);
    shoot(5'(fc), m_top + 4'(fr + 1));
    repeat (3 * P7) @(negedge clk_36MHz);
    #1;
    chk("land_rows", rows_flat, m_flat());
    chk("land_top", top_line, 4'd11);
    chk("land_alive", alive_count, 6'd27);

    // Level 0 spacing with six survivors
    do_reset();
    level = 3'd0;
    do_start();
    for (int i = 0; i < 21; i++) kill_first_live();
    #1 chk("t6_alive", alive_count, 6'd6);
    run_steps(1, 0);
    run_steps(2, P0_EXP);

    repeat (4) @(negedge clk_36MHz);
    chk("hit_q_drained", 64'(hit_q.size()), 64'd0);
    chk("step_q_drained", 64'(step_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
